// File: rtl/ibus_rsp_pkg.sv
// Types, constants and helpers shared by the instruction-bus responder.
`include "riscv_defs.svh"

package ibus_rsp_pkg;

  localparam int unsigned XLEN = `RV_XLEN;

  typedef logic [1:0] hpl_t;
  localparam hpl_t HPL_USER = `RV_HPL_USER;

  // Request-throttle LFSR: x^8+x^6+x^5+x^4+1, Fibonacci form, shifting left.
  localparam logic [7:0] LFSR_SEED = 8'h01;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/ibus_ram.sv
// Synchronous-read RAM with an independent write port. A read and a write to
// the same word in one cycle return the old contents (read-before-write).
module ibus_ram #(
  parameter int unsigned C_ADDR_W = 10,
  parameter int unsigned C_DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_wr_en,
  input  logic [C_ADDR_W-1:0] i_wr_addr,
  input  logic [C_DATA_W-1:0] i_wr_data,
  input  logic                i_rd_en,
  input  logic [C_ADDR_W-1:0] i_rd_addr,
  output logic [C_DATA_W-1:0] o_rd_data
);

  logic [C_DATA_W-1:0] r_mem [2**C_ADDR_W];
  logic [C_DATA_W-1:0] r_rd_data;

  // Write port; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read; the output holds while no read is issued.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/riscv_defs.svh
// Shared RISC-V definitions: data path width and hart privilege level encodings.
`ifndef RISCV_DEFS_SVH
`define RISCV_DEFS_SVH

`define RV_XLEN        32
`define RV_HPL_USER    2'b00
`define RV_HPL_MACHINE 2'b11

`endif

// File: rtl/ibus_rsp.sv
// Instruction-bus responder: decodes fetch requests, reads the instruction RAM
// and returns data or an error through a fixed-latency, back-pressured pipeline.
`include "riscv_defs.svh"

module ibus_rsp
  import ibus_rsp_pkg::*;
#(
  parameter int unsigned          C_MEM_DEPTH_X = 10,
  parameter logic [`RV_XLEN-1:0]  C_BASE_ADDR   = '0,
  parameter longint unsigned      C_USER_BYTES  = 64'd4 << C_MEM_DEPTH_X,
  parameter int unsigned          C_LATENCY     = 1,
  parameter bit                   C_STALL_EN    = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clk_en_i,
  input  logic                     ireqvalid_i,
  output logic                     ireqready_o,
  input  logic [1:0]               ireqhpl_i,
  input  logic [`RV_XLEN-1:0]      ireqaddr_i,
  output logic                     irspvalid_o,
  input  logic                     irspready_i,
  output logic                     irsprerr_o,
  output logic [`RV_XLEN-1:0]      irspdata_o,
  input  logic                     ldwr_i,
  input  logic [C_MEM_DEPTH_X-1:0] ldaddr_i,
  input  logic [`RV_XLEN-1:0]      lddata_i
);

  localparam logic [63:0] LP_MEM_BYTES = 64'd4 << C_MEM_DEPTH_X;
  localparam logic [63:0] LP_USR_BYTES = 64'(C_USER_BYTES);
  localparam int unsigned LP_LAST      = C_LATENCY - 1;

  // Decode
  logic [XLEN:0]              w_diff;
  logic [63:0]                w_off_wide;
  logic                       w_below_base;
  logic                       w_rerr;
  logic [C_MEM_DEPTH_X-1:0]   w_word_idx;

  // Handshake / pipeline control
  logic                       w_stall;
  logic                       w_advance;
  logic                       w_accept;
  logic                       w_ram_wr;
  logic [XLEN-1:0]            w_ram_rdata;
  logic [7:0]                 r_lfsr;

  // Per-stage views, index 0 is the stage fed by the RAM
  logic [C_LATENCY-1:0]       w_vld;
  logic [C_LATENCY-1:0]       w_err;
  logic [XLEN-1:0]            w_data [C_LATENCY];

  // The extra top bit is the borrow: set when the address lies below the base.
  // The range checks work on the full offset, so truncation to a word index
  // cannot alias an out-of-range address onto a valid word.
  assign w_diff       = {1'b0, ireqaddr_i} - {1'b0, C_BASE_ADDR};
  assign w_below_base = w_diff[XLEN];
  assign w_off_wide   = 64'(w_diff[XLEN-1:0]);
  assign w_word_idx   = C_MEM_DEPTH_X'(w_off_wide >> 2);

  assign w_rerr = (|ireqaddr_i[1:0])
                | w_below_base
                | (w_off_wide >= LP_MEM_BYTES)
                | ((ireqhpl_i == HPL_USER) && (w_off_wide >= LP_USR_BYTES));

  // A stalled head response freezes the whole pipeline.
  assign w_stall     = w_vld[LP_LAST] & ~irspready_i;
  assign w_advance   = clk_en_i & ~w_stall;
  assign ireqready_o = ~reset_i & ~w_stall & ~(C_STALL_EN & r_lfsr[0]);
  assign w_accept    = ireqvalid_i & ireqready_o & clk_en_i;
  assign w_ram_wr    = ldwr_i & clk_en_i;

  ibus_ram #(
    .C_ADDR_W (C_MEM_DEPTH_X),
    .C_DATA_W (XLEN)
  ) u_ram (
    .i_clk     (clk_i),
    .i_wr_en   (w_ram_wr),
    .i_wr_addr (ldaddr_i),
    .i_wr_data (lddata_i),
    .i_rd_en   (w_accept),
    .i_rd_addr (w_word_idx),
    .o_rd_data (w_ram_rdata)
  );

  // Throttle LFSR steps on every enabled cycle, stalled or not.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_lfsr <= LFSR_SEED;
    end else if (clk_en_i) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < C_LATENCY; gi++) begin : g_stage
      logic r_vld;
      logic r_err;

      if (gi == 0) begin : g_first
        // Stage 1 captures the accept decision; its data is the RAM output register.
        always_ff @(posedge clk_i) begin
          if (reset_i) begin
            r_vld <= 1'b0;
            r_err <= 1'b0;
          end else if (w_advance) begin
            r_vld <= w_accept;
            r_err <= w_accept & w_rerr;
          end
        end
        // Empty slots and error responses carry zero data.
        assign w_data[gi] = (r_vld & ~r_err) ? w_ram_rdata : '0;
      end else begin : g_next
        logic [XLEN-1:0] r_data;
        // Later stages shift the previous stage forward whenever not stalled.
        always_ff @(posedge clk_i) begin
          if (reset_i) begin
            r_vld  <= 1'b0;
            r_err  <= 1'b0;
            r_data <= '0;
          end else if (w_advance) begin
            r_vld  <= w_vld[gi-1];
            r_err  <= w_err[gi-1];
            r_data <= w_data[gi-1];
          end
        end
        assign w_data[gi] = r_data;
      end

      assign w_vld[gi] = r_vld;
      assign w_err[gi] = r_err;
    end
  endgenerate

  assign irspvalid_o = w_vld[LP_LAST];
  assign irsprerr_o  = w_err[LP_LAST];
  assign irspdata_o  = w_data[LP_LAST];

endmodule
